// File: rtl/add_arbiter_if.sv
// Request/response bundle for add_arbiter: per-requester valid/ready with packed
// operands on the request side and a single valid/ready result channel.
interface add_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 8
) ();
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [W-1:0]      rsp_sum;
  logic              rsp_carry;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry
  );
endinterface

// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one W-bit adder among NREQ requesters; each
// transaction walks IDLE -> EXEC -> RESP and completes on the response handshake.
module add_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 8
) (
  input  logic          clk,
  input  logic          rst,
  add_arbiter_if.slave  bus,
  output logic          busy,
  output logic [15:0]   op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [1:0]   ptr_q, ptr_d;
  logic [1:0]   id_q, id_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W:0]   sum_q, sum_d;
  logic [15:0]  op_count_q, op_count_d;

  logic         gnt_found;
  logic [1:0]   gnt_idx;
  logic [2:0]   cand;

  // First valid requester at or above ptr, wrapping at NREQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      cand = {1'b0, ptr_q} + off[2:0];
      if (cand >= 3'(NREQ)) begin
        cand = cand - 3'(NREQ);
      end
      if (!gnt_found && bus.req_valid[cand[1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[1:0];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    id_d          = id_q;
    a_d           = a_q;
    b_d           = b_q;
    sum_d         = sum_q;
    op_count_d    = op_count_q;
    bus.req_ready = '0;

    unique case (state_q)
      IDLE: begin
        if (gnt_found) begin
          bus.req_ready[gnt_idx] = !rst;
          id_d    = gnt_idx;
          a_d     = bus.req_a[int'(gnt_idx)*W +: W];
          b_d     = bus.req_b[int'(gnt_idx)*W +: W];
          state_d = EXEC;
        end
      end
      EXEC: begin
        sum_d   = {1'b0, a_q} + {1'b0, b_q};
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
          ptr_d   = (id_q == 2'(NREQ - 1)) ? 2'd0 : id_q + 2'd1;
          if (op_count_q != 16'hFFFF) begin
            op_count_d = op_count_q + 16'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      id_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      id_q       <= id_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sum_q      <= sum_d;
      op_count_q <= op_count_d;
    end
  end

  // Result fields are zeroed outside RESP so stale data never leaks out.
  always_comb begin
    bus.rsp_valid = (state_q == RESP) && !rst;
    bus.rsp_id    = bus.rsp_valid ? id_q : '0;
    bus.rsp_sum   = bus.rsp_valid ? sum_q[W-1:0] : '0;
    bus.rsp_carry = bus.rsp_valid ? sum_q[W] : 1'b0;
    busy          = (state_q != IDLE) && !rst;
    op_count      = rst ? '0 : op_count_q;
  end

endmodule

// File: tb/tb_add_arbiter.sv
// Directed self-checking bench for add_arbiter.
module tb_add_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [15:0] op_count;
  int          checks   = 0;
  int          failures = 0;

  add_arbiter_if #(.NREQ(4), .W(8)) bus ();

  add_arbiter #(.NREQ(4), .W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .busy     (busy),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 4'hF;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL rst_req_ready got=%h exp=0", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%b exp=0", bus.rsp_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (op_count !== 16'h0) begin failures++; $display("FAIL rst_op_count got=%h exp=0", op_count); end
    checks++; if ({bus.rsp_id, bus.rsp_sum, bus.rsp_carry} !== 11'h0) begin failures++; $display("FAIL rst_rsp_fields got=%h exp=0", {bus.rsp_id, bus.rsp_sum, bus.rsp_carry}); end
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 4'h0;
    @(negedge clk);
  endtask

  task automatic test_single();
    bus.req_valid = 4'b0001;
    bus.req_a = 32'h0000_0012;
    bus.req_b = 32'h0000_0034;
    bus.rsp_ready = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL single_grant got=%b exp=0001", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 4'b0000;
    #1;
    checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL single_ready_once got=%b exp=0000", bus.req_ready); end
    checks++; if ({busy, bus.rsp_valid} !== 2'b10) begin failures++; $display("FAIL single_exec got busy,valid=%b exp=10", {busy, bus.rsp_valid}); end
    @(negedge clk);
    #1;
    checks++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_carry} !== {1'b1, 2'd0, 8'h46, 1'b0}) begin failures++; $display("FAIL single_rsp got v=%b id=%0d sum=%h c=%b exp v=1 id=0 sum=46 c=0", bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_carry); end
    @(negedge clk);
    #1;
    checks++; if (op_count !== 16'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", op_count); end
    checks++; if ({bus.rsp_valid, bus.rsp_sum, busy} !== 10'h0) begin failures++; $display("FAIL single_idle got v=%b sum=%h busy=%b exp all 0", bus.rsp_valid, bus.rsp_sum, busy); end
  endtask

  task automatic test_overflow();
    // ptr is 1 here; search 1 -> 2 grants requester 2
    bus.req_valid = 4'b0100;
    bus.req_a = 32'h00FF_0000;
    bus.req_b = 32'h0001_0000;
    #1;
    checks++; if (bus.req_ready !== 4'b0100) begin failures++; $display("FAIL ovf_grant got=%b exp=0100", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 4'b0000;
    @(negedge clk);
    #1;
    checks++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_carry} !== {1'b1, 2'd2, 8'h00, 1'b1}) begin failures++; $display("FAIL ovf_rsp got v=%b id=%0d sum=%h c=%b exp v=1 id=2 sum=00 c=1", bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_carry); end
    @(negedge clk);
    #1;
    checks++; if (op_count !== 16'd2) begin failures++; $display("FAIL ovf_count got=%0d exp=2", op_count); end
  endtask

  task automatic test_round_robin();
    logic [1:0] order [5];
    logic [7:0] sums  [4];
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    sums  = '{8'h11, 8'h22, 8'h33, 8'h44};
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 4'hF;
    bus.req_a = 32'h4030_2010;
    bus.req_b = 32'h0403_0201;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (bus.req_ready !== (4'b0001 << order[i])) begin failures++; $display("FAIL rr_grant%0d got=%b exp_id=%0d", i, bus.req_ready, order[i]); end
      @(negedge clk);
      @(negedge clk);
      #1;
      checks++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_sum} !== {1'b1, order[i], sums[order[i]]}) begin failures++; $display("FAIL rr_rsp%0d got v=%b id=%0d sum=%h exp id=%0d sum=%h", i, bus.rsp_valid, bus.rsp_id, bus.rsp_sum, order[i], sums[order[i]]); end
      @(negedge clk);
    end
    bus.req_valid = 4'h0;
    #1;
    checks++; if (op_count !== 16'd5) begin failures++; $display("FAIL rr_count got=%0d exp=5", op_count); end
  endtask

  task automatic test_backpressure();
    // ptr is 1; requester 1 stays valid throughout the stall
    bus.req_valid = 4'b0010;
    bus.rsp_ready = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin failures++; $display("FAIL bp_grant got=%b exp=0010", bus.req_ready); end
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checks++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_carry, bus.req_ready} !== {1'b1, 2'd1, 8'h22, 1'b0, 4'b0000}) begin failures++; $display("FAIL bp_hold%0d got v=%b id=%0d sum=%h c=%b rdy=%b exp v=1 id=1 sum=22 c=0 rdy=0000", i, bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_carry, bus.req_ready); end
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0000;
    @(negedge clk);
    #1;
    checks++; if ({bus.rsp_valid, busy} !== 2'b00) begin failures++; $display("FAIL bp_done got v=%b busy=%b exp 0 0", bus.rsp_valid, busy); end
    checks++; if (op_count !== 16'd6) begin failures++; $display("FAIL bp_count got=%0d exp=6", op_count); end
  endtask

  task automatic test_reset_mid_op();
    // ptr is 2; requester 1 granted, then reset lands while in EXEC
    bus.req_valid = 4'b0010;
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin failures++; $display("FAIL rmid_grant got=%b exp=0010", bus.req_ready); end
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = 4'b0000;
    @(negedge clk);
    #1;
    checks++; if ({bus.rsp_valid, busy, op_count} !== 18'h0) begin failures++; $display("FAIL rmid_reset got v=%b busy=%b cnt=%0d exp all 0", bus.rsp_valid, busy, op_count); end
    rst = 1'b0;
    bus.req_valid = 4'b1001;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL rmid_prio got=%b exp=0001", bus.req_ready); end
    @(negedge clk);
    #1;
    checks++; if ({busy, bus.rsp_valid} !== 2'b10) begin failures++; $display("FAIL rmid_exec got busy,valid=%b exp=10", {busy, bus.rsp_valid}); end
    @(negedge clk);
    #1;
    checks++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_sum} !== {1'b1, 2'd0, 8'h11}) begin failures++; $display("FAIL rmid_rsp0 got v=%b id=%0d sum=%h exp v=1 id=0 sum=11", bus.rsp_valid, bus.rsp_id, bus.rsp_sum); end
    @(negedge clk);
    #1;
    checks++; if (bus.req_ready !== 4'b1000) begin failures++; $display("FAIL rmid_next got=%b exp=1000", bus.req_ready); end
    checks++; if (op_count !== 16'd1) begin failures++; $display("FAIL rmid_count1 got=%0d exp=1", op_count); end
    @(negedge clk);
    bus.req_valid = 4'b0000;
    @(negedge clk);
    #1;
    checks++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_sum} !== {1'b1, 2'd3, 8'h44}) begin failures++; $display("FAIL rmid_rsp3 got v=%b id=%0d sum=%h exp v=1 id=3 sum=44", bus.rsp_valid, bus.rsp_id, bus.rsp_sum); end
    @(negedge clk);
    #1;
    checks++; if ({op_count, busy} !== {16'd2, 1'b0}) begin failures++; $display("FAIL rmid_count2 got cnt=%0d busy=%b exp cnt=2 busy=0", op_count, busy); end
  endtask

  task automatic test_saturation();
    logic [15:0] exp_cnt [3];
    exp_cnt = '{16'hFFFE, 16'hFFFF, 16'hFFFF};
    // Stand-in for 65533 prior completions, which would exceed the cycle budget.
    force dut.op_count_q = 16'hFFFD;
    #1;
    release dut.op_count_q;
    for (int i = 0; i < 3; i++) begin
      bus.req_valid = 4'b0001;
      @(negedge clk);
      bus.req_valid = 4'b0000;
      @(negedge clk);
      #1;
      checks++; if (bus.rsp_valid !== 1'b1) begin failures++; $display("FAIL sat_rsp%0d got v=%b exp=1", i, bus.rsp_valid); end
      @(negedge clk);
      #1;
      checks++; if (op_count !== exp_cnt[i]) begin failures++; $display("FAIL sat_count%0d got=%h exp=%h", i, op_count, exp_cnt[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_round_robin();
    test_backpressure();
    test_reset_mid_op();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the adder; legal values 2..4.
REQ-002 Parameter W, default 8, operand and sum width in bits.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 req_valid  input  NREQ  per-requester request valid.
REQ-006 req_ready  output  NREQ  per-requester accept strobe; at most one bit high per cycle.
REQ-007 req_a  input  NREQ*W  packed operand A; requester i occupies bits [i*W +: W].
REQ-008 req_b  input  NREQ*W  packed operand B, same packing as req_a.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  downstream accepts the result.
REQ-011 rsp_id  output  2  index of the requester that owns the result.
REQ-012 rsp_sum  output  W  (A+B) mod 2^W.
REQ-013 rsp_carry  output  1  carry out of the W-bit addition.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 op_count  output  16  count of completed responses, saturating at 0xFFFF.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, EXEC and RESP.
REQ-017 IDLE: if any req_valid is high, the block SHALL grant the first requester with req_valid high, searching round-robin from index ptr upward and wrapping from NREQ-1 to 0.
REQ-018 req_ready[g] SHALL be high combinationally in IDLE only, for the granted g only; all other bits SHALL be 0.
REQ-019 On the grant edge, the block SHALL latch the operands of g and g itself, and go to EXEC.
REQ-020 EXEC: the block SHALL register the (W+1)-bit sum of the latched operands into rsp_carry and rsp_sum, and go to RESP.
REQ-021 RESP: rsp_valid SHALL be 1, and rsp_id, rsp_sum and rsp_carry SHALL be held stable until the cycle in which rsp_ready is 1.
REQ-022 On the edge where rsp_valid and rsp_ready are both 1, the block SHALL: return to IDLE; set ptr to (g+1) mod NREQ; increment op_count unless it is 0xFFFF.
REQ-023 Latency: a request accepted at edge T SHALL give rsp_valid=1 in the cycle after edge T+1; minimum issue interval is 3 cycles.
REQ-024 The block SHALL accept no new request while busy, and req_valid changes in EXEC or RESP SHALL have no effect.
REQ-025 A requester dropping req_valid before it is granted SHALL NOT be granted.
REQ-026 Arithmetic SHALL wrap modulo 2^W; example: 0xFF+0x01 gives sum 0x00, carry 1.
REQ-027 rsp_sum, rsp_carry and rsp_id SHALL read 0 whenever rsp_valid is 0.
REQ-028 In IDLE with no req_valid high, the state and ptr SHALL be unchanged.

Reset
REQ-029 While rst=1 at a rising edge, the block SHALL force: state=IDLE, ptr=0, op_count=0, latched operands=0.
REQ-030 While rst=1, all outputs SHALL be 0 (req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, busy, op_count).
REQ-031 Reset asserted in EXEC or RESP SHALL discard the in-flight transaction without a response and without incrementing op_count.
REQ-032 In the first cycle after rst deasserts, a pending request SHALL be grantable, with requester 0 having priority.

Verification
REQ-033 Single request: req0 a=0x12, b=0x34, rsp_ready=1 -> req_ready=0001 for one cycle; rsp_valid two cycles later with id=0, sum=0x46, carry=0; op_count=1.
REQ-034 Overflow: req2 a=0xFF, b=0x01 -> id=2, sum=0x00, carry=1.
REQ-035 Round-robin: all four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0; each response id matches its grant.
REQ-036 Backpressure: rsp_ready=0 for 5 cycles during RESP -> rsp_valid and outputs stay stable; no req_ready pulse; one response completes after rsp_ready=1.
REQ-037 Reset mid-op: rst pulsed in EXEC for req1 -> no response; op_count=0; with req0 and req3 then valid, req0 is granted first.
REQ-038 Saturation: op_count preloaded by 65535 completions -> the next completion leaves op_count=0xFFFF.
